neos2test_nios2_qsys_0_oci_dct_packer: RTL and testbench
========================================================

NEOS2TEST_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: neos2test_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL have one clock and one asynchronous, active-low reset; all state changes on rising clk, reset acts immediately on jrst_n low.
REQ-002 SHALL have port clk, input, 1, OCI clock.
REQ-003 SHALL have port jrst_n, input, 1, async active-low reset.
REQ-004 SHALL have port trc_on, input, 1, trace enable.
REQ-005 SHALL have port code_valid, input, 1, a 2-bit direct-control-transfer code is present this cycle.
REQ-006 SHALL have port code, input, 2, DCT code (opaque, all values packed identically).
REQ-007 SHALL have port flush, input, 1, single-cycle request to emit a partial buffer.
REQ-008 SHALL have port frame_ready, input, 1, downstream accepts frame.
REQ-009 SHALL have port overflow_clr, input, 1, clears overflow.
REQ-010 SHALL have port dct_buffer, output, 30, live packing buffer.
REQ-011 SHALL have port dct_count, output, 4, codes held in dct_buffer (0..15).
REQ-012 SHALL have port frame_valid, output, 1, frame slot occupied.
REQ-013 SHALL have port frame_data, output, 30, emitted buffer.
REQ-014 SHALL have port frame_count, output, 4, codes in frame_data (1..15).
REQ-015 SHALL have port overflow, output, 1, sticky: a code was dropped.

Function
REQ-016 SHALL accept a code when code_valid && trc_on && dct_count<15: dct_buffer <= {dct_buffer[27:0], code}, dct_count+1, visible next cycle.
REQ-017 SHALL ignore code_valid while trc_on low (no count change, no overflow).
REQ-018 SHALL treat the slot as free when frame_valid==0 or (frame_valid && frame_ready) this cycle.
REQ-019 SHALL transfer when dct_count==15 and slot free: frame_data<=dct_buffer, frame_count<=15, frame_valid<=1, buffer/count cleared; one cycle latency from full to frame_valid.
REQ-020 SHALL, on a transfer cycle with an accepted code, load the fresh buffer with that code only (dct_buffer={28'b0,code}, dct_count=1).
REQ-021 SHALL, when dct_count==15, slot not free and code_valid&&trc_on, drop the code and set overflow; buffer unchanged.
REQ-022 SHALL register a flush (or trc_on 1->0 edge) as flush_pending; pending transfers a partial buffer (count 1..14) when slot free, then clears; pending with count==0 clears without emitting.
REQ-023 SHALL, when flush_pending and a code arrive together with slot free, emit the buffer first and start the new buffer with the code (as REQ-020).
REQ-024 SHALL hold frame_data/frame_count stable while frame_valid && !frame_ready; clear frame_valid on acceptance unless a new transfer occurs the same cycle.
REQ-025 SHALL use states EMPTY (count 0), FILLING (1..14), FULL (15, waiting slot); FULL->EMPTY on transfer without code, FULL->FILLING on transfer with code.
REQ-026 SHALL clear overflow on overflow_clr; a drop in the same cycle wins (overflow stays 1).

Reset
REQ-027 SHALL on jrst_n low set dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, overflow=0, flush_pending=0, state EMPTY.
REQ-028 SHALL discard a partial buffer and an unaccepted frame on reset mid-operation; no frame emitted after release until new codes arrive.

Structure
REQ-029 SHALL place DCT_CODE_W=2, DCT_DEPTH=15, DCT_BUF_W=30, DCT_CNT_W=4 and the state encoding in the shared OCI package.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 SHALL cover: 15 codes 2'b01 back-to-back, frame_ready=1 -> frame_data=30'h15555555, frame_count=15, frame_valid one cycle after 15th code, dct_count=0.
REQ-032 SHALL cover: 3 codes 11,10,01 then flush -> frame_data=30'h39, frame_count=3.
REQ-033 SHALL cover: frame_ready=0, 31 codes -> first frame held stable, second buffer full at 15, 31st code dropped, overflow=1; overflow_clr -> 0.
REQ-034 SHALL cover: full buffer + code 2'b10 in the transfer cycle -> frame_count=15, dct_count=1, dct_buffer=30'h2.
REQ-035 SHALL cover: 5 codes then trc_on 1->0 -> frame_count=5 emitted; later code_valid with trc_on=0 -> no change.
REQ-036 SHALL cover: jrst_n low mid-fill (count 7) and with frame pending -> all outputs 0 asynchronously, no frame after release.

Source files
------------

// File: rtl/neos2test_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared OCI trace constants: DCT code/buffer geometry and packer state encoding.
package neos2test_nios2_qsys_0_oci_dct_packer_pkg;

  localparam int unsigned DCT_CODE_W = 2;
  localparam int unsigned DCT_DEPTH  = 15;
  localparam int unsigned DCT_BUF_W  = 30;
  localparam int unsigned DCT_CNT_W  = 4;

  localparam logic [DCT_CNT_W-1:0] DCT_FULL_CNT = DCT_CNT_W'(DCT_DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  function automatic logic [1:0] state_of(input logic [DCT_CNT_W-1:0] cnt);
    if (cnt == '0)
      return ST_EMPTY;
    else if (cnt == DCT_FULL_CNT)
      return ST_FULL;
    else
      return ST_FILLING;
  endfunction

endpackage

// File: rtl/neos2test_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit direct-control-transfer codes into 30-bit trace frames with a
// single-entry output slot, flush handling and sticky overflow.
module neos2test_nios2_qsys_0_oci_dct_packer
  import neos2test_nios2_qsys_0_oci_dct_packer_pkg::*;
(
  input  logic                  clk,
  input  logic                  jrst_n,
  input  logic                  trc_on,
  input  logic                  code_valid,
  input  logic [DCT_CODE_W-1:0] code,
  input  logic                  flush,
  input  logic                  frame_ready,
  input  logic                  overflow_clr,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  frame_valid,
  output logic [DCT_BUF_W-1:0]  frame_data,
  output logic [DCT_CNT_W-1:0]  frame_count,
  output logic                  overflow
);

  logic [1:0]           state, state_nx;
  logic [DCT_BUF_W-1:0] buf_nx;
  logic [DCT_CNT_W-1:0] cnt_nx;
  logic                 trc_q;
  logic                 flush_pending, pend_nx;
  logic                 code_in, slot_free, xfer, drop;

  always_comb begin
    code_in   = code_valid && trc_on;
    slot_free = !frame_valid || frame_ready;
    xfer      = slot_free && ((state == ST_FULL) ||
                              (flush_pending && (state != ST_EMPTY)));
    buf_nx    = dct_buffer;
    cnt_nx    = dct_count;
    drop      = 1'b0;
    // A transfer empties the buffer first, so a same-cycle code seeds the fresh one.
    if (xfer) begin
      buf_nx = code_in ? {{(DCT_BUF_W-DCT_CODE_W){1'b0}}, code} : '0;
      cnt_nx = code_in ? DCT_CNT_W'(1) : '0;
    end else if (code_in) begin
      if (state == ST_FULL) begin
        drop = 1'b1;
      end else begin
        buf_nx = {dct_buffer[DCT_BUF_W-DCT_CODE_W-1:0], code};
        cnt_nx = dct_count + DCT_CNT_W'(1);
      end
    end
    state_nx = state_of(cnt_nx);
    // Pending survives only while a non-empty buffer waits on a busy slot.
    pend_nx  = flush || (trc_q && !trc_on) ||
               (flush_pending && !slot_free && (state != ST_EMPTY));
  end

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state         <= ST_EMPTY;
      dct_buffer    <= '0;
      dct_count     <= '0;
      frame_valid   <= 1'b0;
      frame_data    <= '0;
      frame_count   <= '0;
      overflow      <= 1'b0;
      flush_pending <= 1'b0;
      trc_q         <= 1'b0;
    end else begin
      state         <= state_nx;
      dct_buffer    <= buf_nx;
      dct_count     <= cnt_nx;
      flush_pending <= pend_nx;
      trc_q         <= trc_on;
      if (xfer) begin
        frame_valid <= 1'b1;
        frame_data  <= dct_buffer;
        frame_count <= dct_count;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neos2test_nios2_qsys_0_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer with hand-computed expectations.
module tb_neos2test_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        jrst_n;
  logic        trc_on;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush;
  logic        frame_ready;
  logic        overflow_clr;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  neos2test_nios2_qsys_0_oci_dct_packer dut (
    .clk          (clk),
    .jrst_n       (jrst_n),
    .trc_on       (trc_on),
    .code_valid   (code_valid),
    .code         (code),
    .flush        (flush),
    .frame_ready  (frame_ready),
    .overflow_clr (overflow_clr),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_count  (frame_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned n, input logic [1:0] c);
    for (int unsigned i = 0; i < n; i++) begin
      code_valid = 1'b1;
      code       = c;
      tick();
    end
    code_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dct_buffer"},  32'(dct_buffer),  32'h0);
    chk({tag, ".dct_count"},   32'(dct_count),   32'h0);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'h0);
    chk({tag, ".frame_data"},  32'(frame_data),  32'h0);
    chk({tag, ".frame_count"}, 32'(frame_count), 32'h0);
    chk({tag, ".overflow"},    32'(overflow),    32'h0);
  endtask

  initial begin
    jrst_n = 1'b0; trc_on = 1'b0; code_valid = 1'b0; code = 2'b00;
    flush = 1'b0; frame_ready = 1'b0; overflow_clr = 1'b0;
    #3;
    chk_all_zero("reset");
    tick(); tick();
    jrst_n = 1'b1;

    // 15 x 01 back-to-back, slot always ready
    trc_on = 1'b1; frame_ready = 1'b1;
    send(15, 2'b01);
    chk("full.count", 32'(dct_count), 32'd15);
    chk("full.fv_not_yet", 32'(frame_valid), 32'd0);
    tick();
    chk("full.fv", 32'(frame_valid), 32'd1);
    chk("full.data", 32'(frame_data), 32'h15555555);
    chk("full.fcount", 32'(frame_count), 32'd15);
    chk("full.dct_count", 32'(dct_count), 32'd0);
    tick();
    chk("full.fv_drop", 32'(frame_valid), 32'd0);

    // 11,10,01 then flush
    send(1, 2'b11); send(1, 2'b10); send(1, 2'b01);
    chk("part.buffer", 32'(dct_buffer), 32'h39);
    chk("part.count", 32'(dct_count), 32'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("part.fv_pending", 32'(frame_valid), 32'd0);
    tick();
    chk("part.fv", 32'(frame_valid), 32'd1);
    chk("part.data", 32'(frame_data), 32'h39);
    chk("part.fcount", 32'(frame_count), 32'd3);
    chk("part.dct_count", 32'(dct_count), 32'd0);
    tick();
    // flush of an empty buffer emits nothing
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    chk("emptyflush.fv", 32'(frame_valid), 32'd0);

    // back-pressure: 31 codes, first frame held, 31st dropped
    frame_ready = 1'b0;
    send(15, 2'b01);
    send(16, 2'b10);
    chk("ovf.fv", 32'(frame_valid), 32'd1);
    chk("ovf.data_held", 32'(frame_data), 32'h15555555);
    chk("ovf.fcount", 32'(frame_count), 32'd15);
    chk("ovf.dct_count", 32'(dct_count), 32'd15);
    chk("ovf.buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    chk("ovf.flag", 32'(overflow), 32'd1);
    overflow_clr = 1'b1; tick();
    chk("ovf.clr", 32'(overflow), 32'd0);
    code_valid = 1'b1; code = 2'b11; tick(); code_valid = 1'b0;
    chk("ovf.drop_wins", 32'(overflow), 32'd1);
    chk("ovf.buffer_kept", 32'(dct_buffer), 32'h2AAAAAAA);
    tick(); overflow_clr = 1'b0;
    chk("ovf.clr2", 32'(overflow), 32'd0);
    frame_ready = 1'b1; tick();
    chk("ovf.accept_xfer_fv", 32'(frame_valid), 32'd1);
    chk("ovf.accept_xfer_data", 32'(frame_data), 32'h2AAAAAAA);
    chk("ovf.accept_dct_count", 32'(dct_count), 32'd0);
    tick();
    chk("ovf.fv_drop", 32'(frame_valid), 32'd0);

    // full buffer plus code 10 in the transfer cycle
    send(15, 2'b11);
    send(1, 2'b10);
    chk("xc.fv", 32'(frame_valid), 32'd1);
    chk("xc.fcount", 32'(frame_count), 32'd15);
    chk("xc.data", 32'(frame_data), 32'h3FFFFFFF);
    chk("xc.dct_count", 32'(dct_count), 32'd1);
    chk("xc.buffer", 32'(dct_buffer), 32'h2);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("xc.flush_one", 32'(frame_count), 32'd1);
    chk("xc.flush_data", 32'(frame_data), 32'h2);
    tick();

    // 5 codes, then trc_on falls
    send(5, 2'b01);
    trc_on = 1'b0; tick();
    chk("trc.fv_pending", 32'(frame_valid), 32'd0);
    tick();
    chk("trc.fv", 32'(frame_valid), 32'd1);
    chk("trc.fcount", 32'(frame_count), 32'd5);
    chk("trc.data", 32'(frame_data), 32'h155);
    tick();
    send(2, 2'b11);
    chk("trc.off_count", 32'(dct_count), 32'd0);
    chk("trc.off_ovf", 32'(overflow), 32'd0);
    chk("trc.off_fv", 32'(frame_valid), 32'd0);

    // reset mid-fill at count 7 with a held frame
    trc_on = 1'b1; frame_ready = 1'b0;
    send(22, 2'b01);
    chk("rst.pre_count", 32'(dct_count), 32'd7);
    chk("rst.pre_fv", 32'(frame_valid), 32'd1);
    #2 jrst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    tick();
    jrst_n = 1'b1; frame_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst.post_fv", 32'(frame_valid), 32'd0);
    chk("rst.post_count", 32'(dct_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
